// File: rtl/chip_vga_sink.sv
// chip_vga_sink: recovers pixel coordinates from a game's VGA-style output,
// checks the sync timing against the expected mode, and presents a clean,
// registered active-pixel stream once the timing has been seen to be stable.
module chip_vga_sink #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_ce,
    input  logic [3:0]  vga_r,
    input  logic [3:0]  vga_g,
    input  logic [3:0]  vga_b,
    input  logic        vga_hs,
    input  logic        vga_vs,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [11:0] pix_rgb,
    output logic        frame_done,
    output logic        locked,
    output logic [7:0]  err_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Counter landmarks; the visible window starts right after sync + back porch.
    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_START = 10'(H_SYNC + H_BP);
    localparam logic [9:0] H_END   = 10'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [9:0] V_START = 10'(V_SYNC + V_BP);
    localparam logic [9:0] V_END   = 10'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [9:0] X_LAST  = 10'(H_ACTIVE - 1);
    localparam logic [9:0] Y_LAST  = 10'(V_ACTIVE - 1);
    localparam logic [9:0] CNT_MAX = 10'h3FF;
    localparam logic [7:0] ERR_MAX = 8'hFF;

    typedef enum logic [1:0] {
        ST_SEEK   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // Input stage S1 and the previous S1 sync samples for edge detection
    logic [3:0]  s1_r_q, s1_r_d;
    logic [3:0]  s1_g_q, s1_g_d;
    logic [3:0]  s1_b_q, s1_b_d;
    logic        s1_hs_q, s1_hs_d;
    logic        s1_vs_q, s1_vs_d;
    logic        hs_prev_q, hs_prev_d;
    logic        vs_prev_q, vs_prev_d;

    // Timing recovery
    logic [9:0]  h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic        vs_pend_q, vs_pend_d;
    logic        first_h_q, first_h_d;
    logic        first_v_q, first_v_d;

    // Lock tracking
    state_t      state_q, state_d;
    logic        dirty_q, dirty_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    // Output stage S2
    logic        pix_valid_q, pix_valid_d;
    logic [9:0]  pix_x_q, pix_x_d;
    logic [9:0]  pix_y_q, pix_y_d;
    logic [11:0] pix_rgb_q, pix_rgb_d;
    logic        frame_done_q, frame_done_d;

    // Combinational helpers
    logic        hs_fall;
    logic        vs_fall;
    logic        vs_seen;
    logic        line_err;
    logic        frame_err;
    logic        err_flag;
    logic        vs_evt;
    logic        in_active;
    logic [9:0]  x_calc;
    logic [9:0]  y_calc;

    assign hs_fall = ~s1_hs_q & hs_prev_q;
    assign vs_fall = ~s1_vs_q & vs_prev_q;
    // A vsync fall counts for the line boundary it coincides with as well.
    assign vs_seen = vs_pend_q | vs_fall;

    // Capture the game's outputs once per pixel; remember last sync levels.
    always_comb begin
        s1_r_d    = s1_r_q;
        s1_g_d    = s1_g_q;
        s1_b_d    = s1_b_q;
        s1_hs_d   = s1_hs_q;
        s1_vs_d   = s1_vs_q;
        hs_prev_d = hs_prev_q;
        vs_prev_d = vs_prev_q;
        if (pix_ce) begin
            s1_r_d    = vga_r;
            s1_g_d    = vga_g;
            s1_b_d    = vga_b;
            s1_hs_d   = vga_hs;
            s1_vs_d   = vga_vs;
            hs_prev_d = s1_hs_q;
            vs_prev_d = s1_vs_q;
        end
    end

    // Recover h/v position of the S1 pixel and flag line/frame length errors.
    always_comb begin
        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;
        vs_pend_d = vs_pend_q;
        first_h_d = first_h_q;
        first_v_d = first_v_q;
        line_err  = 1'b0;
        frame_err = 1'b0;
        if (pix_ce) begin
            if (hs_fall) begin
                h_cnt_d   = '0;
                first_h_d = 1'b0;
                line_err  = ~first_h_q & (h_cnt_q != H_LAST);
            end else if (h_cnt_q != CNT_MAX) begin
                h_cnt_d = h_cnt_q + 10'd1;
            end

            if (hs_fall) begin
                vs_pend_d = 1'b0;
                if (vs_seen) begin
                    v_cnt_d   = '0;
                    first_v_d = 1'b0;
                    frame_err = ~first_v_q & (v_cnt_q != V_LAST);
                end else if (v_cnt_q != CNT_MAX) begin
                    v_cnt_d = v_cnt_q + 10'd1;
                end
            end else begin
                vs_pend_d = vs_seen;
            end
        end
    end

    assign err_flag = line_err | frame_err;
    assign vs_evt   = pix_ce & vs_fall;

    // Lock FSM: a full error-free frame between two vsync falls earns lock.
    always_comb begin
        state_d = state_q;
        dirty_d = dirty_q;
        case (state_q)
            ST_SEEK: begin
                if (vs_evt) begin
                    state_d = ST_CHECK;
                    dirty_d = 1'b0;
                end
            end
            ST_CHECK: begin
                if (vs_evt) begin
                    if (dirty_q || err_flag) begin
                        dirty_d = 1'b0;
                    end else begin
                        state_d = ST_LOCKED;
                    end
                end else if (err_flag) begin
                    dirty_d = 1'b1;
                end
            end
            ST_LOCKED: begin
                if (err_flag) begin
                    state_d = ST_SEEK;
                end
            end
            default: begin
                state_d = ST_SEEK;
                dirty_d = 1'b0;
            end
        endcase
    end

    // Count timing errors seen while locked; simultaneous errors count once.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_flag && (state_q == ST_LOCKED) && (err_cnt_q != ERR_MAX)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    assign in_active = (h_cnt_d >= H_START) && (h_cnt_d < H_END) &&
                       (v_cnt_d >= V_START) && (v_cnt_d < V_END);
    assign x_calc    = h_cnt_d - H_START;
    assign y_calc    = v_cnt_d - V_START;

    // Build the S2 output word; coordinates and colour hold between strobes.
    always_comb begin
        pix_valid_d  = pix_ce & (state_q == ST_LOCKED) & in_active;
        frame_done_d = pix_valid_d & (x_calc == X_LAST) & (y_calc == Y_LAST);
        pix_x_d      = pix_x_q;
        pix_y_d      = pix_y_q;
        pix_rgb_d    = pix_rgb_q;
        if (pix_valid_d) begin
            pix_x_d   = x_calc;
            pix_y_d   = y_calc;
            pix_rgb_d = {s1_r_q, s1_g_q, s1_b_q};
        end
    end

    // All state registers; reset wins over pix_ce.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r_q       <= '0;
            s1_g_q       <= '0;
            s1_b_q       <= '0;
            s1_hs_q      <= 1'b1;
            s1_vs_q      <= 1'b1;
            hs_prev_q    <= 1'b1;
            vs_prev_q    <= 1'b1;
            h_cnt_q      <= '0;
            v_cnt_q      <= '0;
            vs_pend_q    <= 1'b0;
            first_h_q    <= 1'b1;
            first_v_q    <= 1'b1;
            state_q      <= ST_SEEK;
            dirty_q      <= 1'b0;
            err_cnt_q    <= '0;
            pix_valid_q  <= 1'b0;
            pix_x_q      <= '0;
            pix_y_q      <= '0;
            pix_rgb_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            s1_r_q       <= s1_r_d;
            s1_g_q       <= s1_g_d;
            s1_b_q       <= s1_b_d;
            s1_hs_q      <= s1_hs_d;
            s1_vs_q      <= s1_vs_d;
            hs_prev_q    <= hs_prev_d;
            vs_prev_q    <= vs_prev_d;
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            vs_pend_q    <= vs_pend_d;
            first_h_q    <= first_h_d;
            first_v_q    <= first_v_d;
            state_q      <= state_d;
            dirty_q      <= dirty_d;
            err_cnt_q    <= err_cnt_d;
            pix_valid_q  <= pix_valid_d;
            pix_x_q      <= pix_x_d;
            pix_y_q      <= pix_y_d;
            pix_rgb_q    <= pix_rgb_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign pix_valid  = pix_valid_q;
    assign pix_x      = pix_x_q;
    assign pix_y      = pix_y_q;
    assign pix_rgb    = pix_rgb_q;
    assign frame_done = frame_done_q;
    assign locked     = (state_q == ST_LOCKED);
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_chip_vga_sink.sv
// Testbench for chip_vga_sink using a reduced video mode (16x11 total,
// 8x6 visible) so that many frames fit in a short run. Stimulus pushes the
// expected output pixels into a scoreboard; a monitor pops them on pix_valid.
module tb_chip_vga_sink;

    localparam int HA = 8, HF = 2, HS = 3, HB = 3;
    localparam int VA = 6, VF = 1, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;   // 16
    localparam int VT = VA + VF + VS + VB;   // 11
    localparam int HOFF = HS + HB;           // 6
    localparam int VOFF = VS + VB;           // 4

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_ce;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs;
    logic        pix_valid;
    logic [9:0]  pix_x, pix_y;
    logic [11:0] pix_rgb;
    logic        frame_done;
    logic        locked;
    logic [7:0]  err_cnt;

    chip_vga_sink #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk(clk), .rst(rst), .pix_ce(pix_ce),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .pix_rgb(pix_rgb), .frame_done(frame_done),
        .locked(locked), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int rgb;
        bit fd;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   frame_idx = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Monitor: each pix_valid strobe must match the oldest expected pixel.
    always @(negedge clk) begin
        exp_t e;
        if (pix_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_pix_valid: got x=%0d y=%0d, expected no pixel", pix_x, pix_y);
            end else begin
                e = sb.pop_front();
                chk("pix_x", int'(pix_x), e.x);
                chk("pix_y", int'(pix_y), e.y);
                chk("pix_rgb", int'(pix_rgb), e.rgb);
                chk("frame_done", int'(frame_done), int'(e.fd));
                $display("pixel x=%0d y=%0d rgb=%03h fd=%0d", pix_x, pix_y, pix_rgb, frame_done);
            end
        end else if (frame_done) begin
            n_checks++;
            $display("FAIL frame_done_without_valid: got 1, expected 0");
        end
    end

    // One pixel: pix_ce high for one clk, then three idle clks.
    task automatic drive_px(input logic hs, input logic vs, input logic [3:0] r,
                            input logic [3:0] g, input logic [3:0] b);
        vga_hs = hs;
        vga_vs = vs;
        vga_r  = r;
        vga_g  = g;
        vga_b  = b;
        pix_ce = 1'b1;
        @(posedge clk);
        #1;
        pix_ce = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // One frame. lk_in: bench expects lock throughout (until short line / reset).
    task automatic gen_frame(input int nlines, input bit lk_in, input int short_line,
                             input int rst_line, input int rst_h,
                             input int pause_line, input int pause_h);
        bit lk;
        lk = lk_in;
        for (int v = 0; v < nlines; v++) begin
            int len;
            len = (v == short_line) ? HT - 1 : HT;
            for (int h = 0; h < len; h++) begin
                logic [3:0] r, g, b;
                bit act, do_rst;
                exp_t e;
                r = h[3:0];
                g = v[3:0];
                b = frame_idx[3:0];
                act = (h >= HOFF) && (h < HOFF + HA) && (v >= VOFF) && (v < VOFF + VA);
                do_rst = (v == rst_line) && (h == rst_h);
                if (lk && act && !do_rst) begin
                    e.x   = h - HOFF;
                    e.y   = v - VOFF;
                    e.rgb = (int'(r) << 8) | (int'(g) << 4) | int'(b);
                    e.fd  = (e.x == HA - 1) && (e.y == VA - 1);
                    sb.push_back(e);
                end
                drive_px((h < HS) ? 1'b0 : 1'b1, (v < VS) ? 1'b0 : 1'b1, r, g, b);
                if (v == pause_line && h == pause_h) begin
                    repeat (100) @(posedge clk);
                    #1;
                    chk("pause_pix_x", int'(pix_x), h - 1 - HOFF);
                    chk("pause_pix_y", int'(pix_y), v - VOFF);
                    chk("pause_locked", int'(locked), 1);
                end
                if (do_rst) begin
                    rst = 1'b1;
                    @(posedge clk);
                    #1;
                    rst = 1'b0;
                    chk("rst_locked", int'(locked), 0);
                    chk("rst_pix_valid", int'(pix_valid), 0);
                    chk("rst_err_cnt", int'(err_cnt), 0);
                    lk = 1'b0;
                end
            end
            if (v == short_line) lk = 1'b0;
        end
        frame_idx++;
    endtask

    initial begin
        rst    = 1'b1;
        pix_ce = 1'b0;
        vga_hs = 1'b1;
        vga_vs = 1'b1;
        vga_r  = '0;
        vga_g  = '0;
        vga_b  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_locked", int'(locked), 0);
        chk("reset_pix_valid", int'(pix_valid), 0);
        chk("reset_frame_done", int'(frame_done), 0);
        chk("reset_err_cnt", int'(err_cnt), 0);
        chk("reset_pix_x", int'(pix_x), 0);
        chk("reset_pix_y", int'(pix_y), 0);
        chk("reset_pix_rgb", int'(pix_rgb), 0);
        rst = 1'b0;

        // A: first frame, seeking/checking -> no output
        gen_frame(VT, 1'b0, -1, -1, -1, -1, -1);
        chk("A_locked", int'(locked), 0);
        // B, C: locked after 2nd vsync fall
        gen_frame(VT, 1'b1, -1, -1, -1, -1, -1);
        chk("B_locked", int'(locked), 1);
        chk("B_err_cnt", int'(err_cnt), 0);
        gen_frame(VT, 1'b1, -1, -1, -1, -1, -1);
        chk("C_locked", int'(locked), 1);
        // D: one short line while locked -> unlock, one error
        gen_frame(VT, 1'b1, VOFF + 2, -1, -1, -1, -1);
        chk("D_locked", int'(locked), 0);
        chk("D_err_cnt", int'(err_cnt), 1);
        // E: seek->check, F: relocked, with a 100-clk pix_ce pause
        gen_frame(VT, 1'b0, -1, -1, -1, -1, -1);
        chk("E_locked", int'(locked), 0);
        gen_frame(VT, 1'b1, -1, -1, -1, VOFF + 1, HOFF + 3);
        chk("F_locked", int'(locked), 1);
        chk("F_err_cnt", int'(err_cnt), 1);
        // G: reset mid-line while locked
        gen_frame(VT, 1'b1, -1, VOFF + 1, HOFF + 3, -1, -1);
        chk("G_locked", int'(locked), 0);
        // H: short frame while checking, I: clean frame, J: locked again
        gen_frame(VT - 1, 1'b0, -1, -1, -1, -1, -1);
        chk("H_locked", int'(locked), 0);
        gen_frame(VT, 1'b0, -1, -1, -1, -1, -1);
        chk("I_locked", int'(locked), 0);
        chk("I_err_cnt", int'(err_cnt), 0);
        gen_frame(VT, 1'b1, -1, -1, -1, -1, -1);
        chk("J_locked", int'(locked), 1);
        chk("J_err_cnt", int'(err_cnt), 0);

        repeat (8) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
